// File: rtl/tmul_mv_acc.sv
// tmul_mv_acc: N-vector times NxN matrix multiply-accumulate, one matrix column per cycle.
// Build option TMUL_SAT_EN: saturating accumulation with a sticky ovf flag (else wrap, ovf=0).
module tmul_mv_acc #(
    parameter int N = 8,
    parameter int W = 32,
    localparam int CW = 2 * W + $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   a_flat,
    input  logic [N*N*W-1:0] b_flat,
    input  logic             tsigned,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*CW-1:0]  c_flat,
    output logic             ovf,
    output logic [1:0]       dbg_state
);
    localparam int KW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Handshake: a transfer occurs on a rising edge with valid && ready both high;
    // ready never depends on valid, and out_valid/c_flat hold until out_ready.
    state_e        state_q, state_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic          tsigned_q, tsigned_d;
    logic [W-1:0]  a_q [N];
    logic [W-1:0]  a_d [N];
    logic [W-1:0]  b_q [N][N];
    logic [W-1:0]  b_d [N][N];
    logic [CW-1:0] acc_q [N];
    logic [CW-1:0] acc_d [N];

    logic [W-1:0]   a_col;
    logic [2*W-1:0] a_x;
    logic [2*W-1:0] b_x [N];
    logic [2*W-1:0] prod [N];
    logic [CW-1:0]  prod_x [N];
    logic [CW-1:0]  acc_nx [N];

`ifdef TMUL_SAT_EN
    logic          ovf_q, ovf_d;
    logic [CW:0]   sum_x [N];
    logic [N-1:0]  sat_v;
`endif

    // Operands are pre-extended to 2W, so the low 2W bits of the product are exact
    // for both signed and unsigned interpretation.
    always_comb begin
        a_col = a_q[cnt_q];
        a_x   = tsigned_q ? {{W{a_col[W-1]}}, a_col} : {{W{1'b0}}, a_col};
        for (int i = 0; i < N; i++) begin
            b_x[i]    = tsigned_q ? {{W{b_q[i][cnt_q][W-1]}}, b_q[i][cnt_q]}
                                  : {{W{1'b0}}, b_q[i][cnt_q]};
            prod[i]   = a_x * b_x[i];
            prod_x[i] = {{(CW-2*W){tsigned_q & prod[i][2*W-1]}}, prod[i]};
`ifdef TMUL_SAT_EN
            sum_x[i] = {tsigned_q & acc_q[i][CW-1], acc_q[i]}
                     + {tsigned_q & prod_x[i][CW-1], prod_x[i]};
            sat_v[i] = tsigned_q ? (sum_x[i][CW] != sum_x[i][CW-1]) : sum_x[i][CW];
            if (!sat_v[i]) begin
                acc_nx[i] = sum_x[i][CW-1:0];
            end else if (!tsigned_q) begin
                acc_nx[i] = '1;
            end else begin
                acc_nx[i] = {sum_x[i][CW], {(CW-1){~sum_x[i][CW]}}};
            end
`else
            acc_nx[i] = acc_q[i] + prod_x[i];
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tsigned_d = tsigned_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
`ifdef TMUL_SAT_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int j = 0; j < N; j++) begin
                        a_d[j] = a_flat[j*W +: W];
                    end
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            b_d[i][j] = b_flat[(i*N+j)*W +: W];
                        end
                    end
                    tsigned_d = tsigned;
                    cnt_d     = '0;
                    state_d   = RUN;
                    if (acc_clear) begin
                        for (int i = 0; i < N; i++) begin
                            acc_d[i] = '0;
                        end
`ifdef TMUL_SAT_EN
                        ovf_d = 1'b0;
`endif
                    end
                end
            end
            RUN: begin
                acc_d = acc_nx;
`ifdef TMUL_SAT_EN
                ovf_d = ovf_q | (|sat_v);
`endif
                cnt_d = cnt_q + KW'(1);
                if (cnt_q == KW'(N-1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tsigned_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_q[i]   <= '0;
                acc_q[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    b_q[i][j] <= '0;
                end
            end
`ifdef TMUL_SAT_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tsigned_q <= tsigned_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
`ifdef TMUL_SAT_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            c_flat[i*CW +: CW] = acc_q[i];
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dbg_state = state_q;
`ifdef TMUL_SAT_EN
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_tmul_mv_acc.sv
// Self-checking bench for tmul_mv_acc: an 8x8/32-bit instance and a 2x2/8-bit instance
// checked against a wide-integer model of the multiply-accumulate rules.
module tb_tmul_mv_acc;
    logic clk;
    logic rst;

    logic           iv8, ir8, tsg8, clr8, ovl8, ord8, ovf8;
    logic [255:0]   a8;
    logic [2047:0]  b8;
    logic [535:0]   c8;
    logic [1:0]     st8;

    logic           iv2, ir2, tsg2, clr2, ovl2, ord2, ovf2;
    logic [15:0]    a2;
    logic [31:0]    b2;
    logic [33:0]    c2;
    logic [1:0]     st2;

    logic [31:0]    ma [8];
    logic [31:0]    mb [8][8];
    logic [127:0]   h8 [8];
    logic [127:0]   h2 [8];
    bit             ov8, ov2;
    int             checks, failures;

    tmul_mv_acc #(.N(8), .W(32)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a_flat(a8), .b_flat(b8),
        .tsigned(tsg8), .acc_clear(clr8), .out_valid(ovl8), .out_ready(ord8),
        .c_flat(c8), .ovf(ovf8), .dbg_state(st8)
    );

    tmul_mv_acc #(.N(2), .W(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a_flat(a2), .b_flat(b2),
        .tsigned(tsg2), .acc_clear(clr2), .out_valid(ovl2), .out_ready(ord2),
        .c_flat(c2), .ovf(ovf2), .dbg_state(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Interpret the low w bits of v as signed or unsigned, as a 128-bit integer.
    function automatic logic signed [127:0] sx(input logic [127:0] v, input int w, input bit sg);
        logic signed [127:0] r;
        r = $signed(v & ((128'd1 << w) - 128'd1));
        if (sg && v[w-1]) r = r - $signed(128'd1 << w);
        return r;
    endfunction

    task automatic model_tile(input int n, input int w, input int cw, input bit sg,
                              input bit clr, inout logic [127:0] held [8], inout bit ov);
        logic signed [127:0] s, lo, hi;
        if (clr) begin
            for (int i = 0; i < 8; i++) held[i] = '0;
            ov = 1'b0;
        end
        if (sg) begin
            lo = -$signed(128'd1 << (cw - 1));
            hi = $signed(128'd1 << (cw - 1)) - 1;
        end else begin
            lo = '0;
            hi = $signed(128'd1 << cw) - 1;
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = sx(held[i], cw, sg) + sx({96'd0, ma[j]}, w, sg) * sx({96'd0, mb[i][j]}, w, sg);
`ifdef TMUL_SAT_EN
                if (s > hi) begin
                    s = hi;
                    ov = 1'b1;
                end else if (s < lo) begin
                    s = lo;
                    ov = 1'b1;
                end
`endif
                held[i] = s & ((128'd1 << cw) - 128'd1);
            end
        end
    endtask

    task automatic txn8(input bit sg, input bit clr, input int hold);
        int lat;
        @(negedge clk);
        chk("in_ready8_idle", ir8, 1);
        for (int j = 0; j < 8; j++) a8[j*32 +: 32] = ma[j];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) b8[(i*8+j)*32 +: 32] = mb[i][j];
        tsg8 = sg;
        clr8 = clr;
        iv8  = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        model_tile(8, 32, 67, sg, clr, h8, ov8);
        lat = 0;
        while (!ovl8 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency8", lat, 8);
        for (int i = 0; i < 8; i++) chk("c8", c8[i*67 +: 67], h8[i]);
        chk("ovf8", ovf8, ov8);
        for (int t = 0; t < hold; t++) begin
            @(negedge clk);
            iv8 = 1'b1;
            for (int j = 0; j < 8; j++) a8[j*32 +: 32] = $urandom();
            tsg8 = 1'($urandom_range(0, 1));
            clr8 = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_out_valid8", ovl8, 1);
            chk("hold_in_ready8", ir8, 0);
            for (int i = 0; i < 8; i++) chk("hold_c8", c8[i*67 +: 67], h8[i]);
        end
        @(negedge clk);
        iv8  = 1'b0;
        ord8 = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid8", ovl8, 0);
        chk("release_in_ready8", ir8, 1);
        @(negedge clk);
        ord8 = 1'b0;
    endtask

    task automatic txn2(input bit sg, input bit clr);
        int lat;
        @(negedge clk);
        chk("in_ready2_idle", ir2, 1);
        for (int j = 0; j < 2; j++) a2[j*8 +: 8] = ma[j][7:0];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) b2[(i*2+j)*8 +: 8] = mb[i][j][7:0];
        tsg2 = sg;
        clr2 = clr;
        iv2  = 1'b1;
        @(posedge clk);
        #1;
        iv2 = 1'b0;
        if (clr) chk("ovf2_clear_on_accept", ovf2, 0);
        model_tile(2, 8, 17, sg, clr, h2, ov2);
        lat = 0;
        while (!ovl2 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency2", lat, 2);
        for (int i = 0; i < 2; i++) chk("c2", c2[i*17 +: 17], h2[i]);
        chk("ovf2", ovf2, ov2);
        @(negedge clk);
        ord2 = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid2", ovl2, 0);
        @(negedge clk);
        ord2 = 1'b0;
    endtask

    task automatic rand_ops();
        for (int j = 0; j < 8; j++) begin
            ma[j] = $urandom();
            for (int i = 0; i < 8; i++) mb[i][j] = $urandom();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        {iv8, tsg8, clr8, ord8, iv2, tsg2, clr2, ord2} = '0;
        a8 = '0;
        b8 = '0;
        a2 = '0;
        b2 = '0;
        ov8 = 1'b0;
        ov2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            h8[i] = '0;
            h2[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready8", ir8, 1);
        chk("reset_out_valid8", ovl8, 0);
        for (int i = 0; i < 8; i++) chk("reset_c8", c8[i*67 +: 67], 0);
        chk("reset_ovf8", ovf8, 0);
        chk("reset_in_ready2", ir2, 1);
        chk("reset_out_valid2", ovl2, 0);
        chk("reset_c2", c2, 0);
        chk("reset_ovf2", ovf2, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int j = 0; j < 8; j++) begin
            ma[j] = 32'd1;
            for (int i = 0; i < 8; i++) mb[i][j] = (i == j) ? 32'd1 : 32'd0;
        end
        txn8(1'b0, 1'b1, 0);
        chk("identity_c0", c8[66:0], 1);
        chk("identity_c7", c8[7*67 +: 67], 1);

        for (int j = 0; j < 8; j++) begin
            ma[j] = 32'(j + 1);
            for (int i = 0; i < 8; i++) mb[i][j] = 32'd2;
        end
        txn8(1'b0, 1'b1, 0);
        chk("weighted_c3", c8[3*67 +: 67], 72);
        txn8(1'b0, 1'b0, 0);
        chk("weighted_acc_c3", c8[3*67 +: 67], 144);

        for (int j = 0; j < 8; j++) begin
            ma[j] = 32'hFFFF_FFFF;
            for (int i = 0; i < 8; i++) mb[i][j] = 32'd3;
        end
        txn8(1'b1, 1'b1, 0);
        chk("signed_c0", c8[66:0], 67'h7_FFFF_FFFF_FFFF_FFE8);
        txn8(1'b0, 1'b1, 0);
        chk("unsigned_c0", c8[66:0], 67'h17_FFFF_FFE8);

        rand_ops();
        txn8(1'($urandom_range(0, 1)), 1'b1, 5);
        txn8(1'b0, 1'b0, 0);

        rand_ops();
        @(negedge clk);
        for (int j = 0; j < 8; j++) a8[j*32 +: 32] = ma[j];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) b8[(i*8+j)*32 +: 32] = mb[i][j];
        tsg8 = 1'b0;
        clr8 = 1'b1;
        iv8  = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrun_rst_out_valid8", ovl8, 0);
        chk("midrun_rst_in_ready8", ir8, 1);
        for (int i = 0; i < 8; i++) chk("midrun_rst_c8", c8[i*67 +: 67], 0);
        for (int i = 0; i < 8; i++) begin
            h8[i] = '0;
            h2[i] = '0;
        end
        ov8 = 1'b0;
        ov2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        txn8(1'b0, 1'b0, 0);

        for (int t = 0; t < 6; t++) begin
            rand_ops();
            txn8(1'($urandom_range(0, 1)), (t == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 0);
        end

        for (int j = 0; j < 2; j++) begin
            ma[j] = 32'hFF;
            for (int i = 0; i < 2; i++) mb[i][j] = 32'hFF;
        end
        txn2(1'b0, 1'b1);
        chk("ovf_tile1_c0", c2[16:0], 130050);
        txn2(1'b0, 1'b0);
`ifdef TMUL_SAT_EN
        chk("ovf_tile2_c0", c2[16:0], 131071);
        chk("ovf_tile2_flag", ovf2, 1);
`else
        chk("ovf_tile2_c0", c2[16:0], 129028);
        chk("ovf_tile2_flag", ovf2, 0);
`endif
        txn2(1'b0, 1'b1);
        chk("ovf_cleared_c1", c2[33:17], 130050);
        chk("ovf_cleared_flag", ovf2, 0);

        for (int t = 0; t < 8; t++) begin
            rand_ops();
            txn2(1'($urandom_range(0, 1)), (t == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tmul_mv_acc.md
Name: tmul_mv_acc

Overview:
- Parametrised, handshaked successor to the fixed 8x8 32-bit tile multiplier.
- Computes an N-element vector times an NxN matrix: c[i] = sum over j of a[j]*b[i][j].
- Processes one matrix column per cycle using N multipliers, one per row.
- Optionally accumulates onto the previous result, so K-dimension tiling needs no external adder; sits between operand buffers and the tile result writeback.

Parameters:
N, 8, vector length and matrix dimension (>=2).
W, 32, operand element width in bits.
CW, 2*W+$clog2(N), accumulator/result element width (derived localparam, not overridable).

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  reset, asynchronous, active-low; state cleared while rst==0.
in_valid  in  1  operand set valid.
in_ready  out  1  block can accept an operand set.
a_flat  in  N*W  vector; a[j] = a_flat[j*W +: W].
b_flat  in  N*N*W  matrix; b[i][j] = b_flat[(i*N+j)*W +: W].
tsigned  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
acc_clear  in  1  1 = start from 0, 0 = add onto held result; sampled at accept.
out_valid  out  1  result valid.
out_ready  in  1  consumer takes result.
c_flat  out  N*CW  result; c[i] = c_flat[i*CW +: CW].
ovf  out  1  sticky overflow flag (see Optional Feature).

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, all acc=0, c_flat=0, ovf=0, column counter=0.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - register a, b, tsigned, acc_clear;
  - if acc_clear==1, acc<=0, otherwise acc keeps its value;
  - counter<=0; go to RUN.
- RUN: in_ready=0. Each edge: acc[i] <= acc[i] + ext(a[k])*ext(b[i][k]) for all i in parallel, k=counter; counter++.
  - ext is sign- or zero-extension to CW according to the registered tsigned.
  - After the edge processing k=N-1, go to DONE.
- DONE: out_valid=1; c_flat mirrors acc and is stable while out_valid=1.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready=0 in DONE, so no new accept in the same cycle as out_ready.
- Latency: out_valid rises exactly N edges after the accepting edge.
- Throughput: one operand set per N+2 cycles with out_ready tied high.
- Input changes while in RUN or DONE are ignored; operands are held in internal registers.
- Arithmetic: products are full 2W-bit. The default sum wraps modulo 2^CW, in CW-bit two's complement when tsigned=1.
- Accumulating with a different tsigned than the held result is allowed: the held bits are reused unchanged.
- Reset mid-operation: abort immediately, return to reset values, result lost.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro TMUL_SAT_EN.
- Defined:
  - each acc[i] update saturates to the CW-bit range: signed [-2^(CW-1), 2^(CW-1)-1] or unsigned [0, 2^CW-1] per the registered tsigned;
  - any saturation event sets ovf=1;
  - ovf is cleared only by reset or by an accept with acc_clear=1.
- Undefined: accumulation wraps and ovf is tied to 0.

Test Plan:
- Identity (N=8, W=32): a[j]=1 for all j, b=identity, tsigned=0, acc_clear=1 -> out_valid 8 edges after accept, c[i]=1 for all i, ovf=0.
- Weighted sum: a[j]=j+1, all b=2, unsigned -> c[i]=72 for all i. Repeat with acc_clear=0 -> c[i]=144.
- Signed: a[j]=0xFFFFFFFF, b=3, tsigned=1 -> c[i] = -24, i.e. 67-bit 0x7_FFFF_FFFF_FFFF_FFE8. Same operands with tsigned=0 -> c[i]=0x17_FFFF_FFE8.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> c_flat stable, in_ready=0, a new in_valid is ignored. Release -> one-cycle out_valid drop, in_ready=1, then the next set is accepted.
- Reset mid-RUN: drop rst at counter=3 -> out_valid=0, in_ready=1, c_flat=0 immediately. Next transaction gives the correct result.
- Overflow (N=2, W=8, CW=17): a=b=0xFF unsigned, two tiles with acc_clear=1 then acc_clear=0.
  - Without TMUL_SAT_EN: c[i]=129028, ovf=0.
  - With TMUL_SAT_EN: c[i]=131071, ovf=1; ovf clears on the next acc_clear=1 accept.
